multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle control FSM directly upstream of the 16-bit datapath; drives its control inputs
//  (RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOP).
//  Accepts one 32-bit instruction per valid/ready handshake, decodes opcode [31:26], sequences
//  DECODE/EXEC/MEM/WB and gates write strobes so each is asserted only in its owning state.
// PARAMETERS
//  MEM_LAT   1  cycles MemRead/MemWrite held in MEM state (legal >= 1)
//  OPCODE_W  6  opcode field width, Instruction[31:26]
//  ALUOP_W   2  ALUOP width
// PORTS
//  clock        in   1   system clock, rising edge
//  reset        in   1   synchronous, active-high
//  instr_valid  in   1   upstream has an instruction on Instruction
//  instr_ready  out  1   high only in IDLE; transfer = instr_valid & instr_ready
//  Instruction  in   32  captured into internal register on transfer
//  RegDst       out  1   1 = rd (R-type), 0 = rt
//  ALUSrc       out  1   1 = sign-extended imm[15:0]
//  MemtoReg     out  1   1 = write-back from memory
//  ALUOP        out  2   00 add (lw/sw/addi), 01 sub (beq), 10 funct (R-type), 11 unused
//  Branch       out  1   one-cycle strobe, EXEC of beq
//  MemRead      out  1   MEM state of lw, MEM_LAT cycles
//  MemWrite     out  1   MEM state of sw, MEM_LAT cycles
//  RegWrite     out  1   one-cycle strobe, WB state
//  busy         out  1   ~instr_ready
//  done         out  1   one-cycle pulse in final state of each instruction
//  illegal_op   out  1   sticky trap flag (ILLEGAL_TRAP_EN only; else tied 0)
// BEHAVIOUR
//  Reset: state IDLE, instr reg 0, MEM counter 0, every output 0 except instr_ready=1.
//  Reset mid-instruction aborts same edge; no strobe asserted in the reset cycle or the next.
//  States: IDLE -> DECODE -> EXEC -> {MEM, WB, IDLE}; MEM -> {WB, IDLE}; WB -> IDLE; TRAP.
//  Opcodes: R 000000, addi 001000, lw 100011, sw 101011, beq 000100; all others illegal.
//  DECODE: all strobes 0; RegDst/ALUSrc/ALUOP/MemtoReg set from opcode, held constant to IDLE.
//  Paths / cycles after transfer edge (done in last):
//   R-type: DECODE, EXEC, WB(RegWrite)                   = 3
//   addi:   DECODE, EXEC, WB(RegWrite)                   = 3
//   lw:     DECODE, EXEC, MEM x MEM_LAT(MemRead), WB(RegWrite, MemtoReg=1) = 3+MEM_LAT
//   sw:     DECODE, EXEC, MEM x MEM_LAT(MemWrite)        = 2+MEM_LAT
//   beq:    DECODE, EXEC(Branch, ALUOP=01)               = 2
//  MEM counter: width $clog2(MEM_LAT+1); loads 0 on MEM entry, exits when count==MEM_LAT-1.
//  In IDLE all control levels return to 0 on the next edge after done.
//  instr_valid while busy is ignored; Instruction not re-sampled until next IDLE transfer.
//  Back-to-back: valid held high -> next transfer on the cycle after done (IDLE for 1 cycle).
//  Never two strobes in one cycle except RegWrite with MemtoReg (a level) in lw WB.
// CONFIGURATION
//  CTRL_ILLEGAL_TRAP_EN defined: illegal opcode in DECODE -> TRAP; illegal_op=1 sticky,
//   instr_ready=0, no strobes, done not pulsed; only reset leaves TRAP.
//  Undefined: illegal opcode executes as NOP: DECODE -> IDLE with done pulse, no strobes;
//   illegal_op tied 0; TRAP state absent.
// STRUCTURE
//  Package ctrl_pkg: opcode localparams, ALUOP encodings, state encoding, ctrl_word_t
//   {RegDst, ALUSrc, MemtoReg, ALUOP, is_lw, is_sw, is_beq, is_wb, illegal}.
//  Sub-module ctrl_decode: combinational opcode -> ctrl_word_t; FSM and counter stay in top.
// TESTING
//  Reset with valid=1 held: outputs 0, instr_ready=1; release -> transfer next edge.
//  R-type 0x00004200, ALUOP expect 10: RegDst=1, RegWrite only 3rd cycle after transfer, done.
//  addi 0x20084200: ALUSrc=1, RegDst=0, ALUOP=00, RegWrite 1 cycle; back-to-back R-type follows.
//  lw 0x8C080004 MEM_LAT=3: MemRead exactly 3 cycles, then WB RegWrite=1, MemtoReg=1; done at +6.
//  sw 0xAC080004 then beq 0x10000002: MemWrite 1 cycle (MEM_LAT=1), no RegWrite; Branch 1 cycle.
//  Illegal 0xFC000000 both builds; reset asserted during lw MEM: MemRead low next cycle, IDLE.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, ALUOP codes, FSM states, decoded control word.
// The TRAP state exists only when CTRL_ILLEGAL_TRAP_EN is defined.
package ctrl_pkg;

  localparam int OPC_W = 6;
  localparam int AOP_W = 2;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;

  localparam logic [AOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [AOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [AOP_W-1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
`ifdef CTRL_ILLEGAL_TRAP_EN
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
`else
    S_WB     = 3'd4
`endif
  } state_t;

  typedef struct packed {
    logic             reg_dst;
    logic             alu_src;
    logic             mem_to_reg;
    logic [AOP_W-1:0] alu_op;
    logic             is_lw;
    logic             is_sw;
    logic             is_beq;
    logic             is_wb;
    logic             illegal;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps Instruction[31:26] onto the control word the FSM sequences.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output ctrl_word_t       ctrl
);

  always_comb begin
    // NOTE: assigning a full default before the case keeps every field driven on every path, so no latch is inferred.
    ctrl = CTRL_NOP;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst = 1'b1;
        ctrl.alu_op  = ALUOP_FUNCT;
        ctrl.is_wb   = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALUOP_ADD;
        ctrl.is_wb   = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.is_lw      = 1'b1;
        ctrl.is_wb      = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALUOP_ADD;
        ctrl.is_sw   = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_op = ALUOP_SUB;
        ctrl.is_beq = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM (IDLE/DECODE/EXEC/MEM/WB) driving the 16-bit datapath control inputs.
// Define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes in a sticky TRAP state instead of treating them as NOPs.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int MEM_LAT  = 1,
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [31:0]        Instruction,
  output logic               RegDst,
  output logic               ALUSrc,
  output logic               MemtoReg,
  output logic [ALUOP_W-1:0] ALUOP,
  output logic               Branch,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               busy,
  output logic               done,
  output logic               illegal_op
);

  localparam int            CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      instr_q;
  logic [CNT_W-1:0] mem_cnt;
  ctrl_word_t       ctrl;
  logic             xfer;
  logic             done_nxt;
  logic             active;
  logic             in_instr;
  logic             unused_instr_bits;

  assign xfer = instr_valid & instr_ready;

  ctrl_decode u_decode (
    .opcode (instr_q[31 -: OPCODE_W]),
    .ctrl   (ctrl)
  );

  // Only the opcode drives control; the remaining fields belong to the datapath.
  assign unused_instr_bits = ^instr_q[31-OPCODE_W:0];

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state   <= S_IDLE;
      instr_q <= '0;
      mem_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        instr_q <= Instruction;
      end
      if (state_nxt == S_MEM && state != S_MEM) begin
        mem_cnt <= '0;
      end else if (state == S_MEM) begin
        mem_cnt <= mem_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (xfer) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (ctrl.illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_nxt = S_TRAP;
`else
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
`endif
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ctrl.is_beq) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else if (ctrl.is_lw || ctrl.is_sw) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (mem_cnt == CNT_LAST) begin
          if (ctrl.is_wb) begin
            state_nxt = S_WB;
          end else begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      S_WB: begin
        state_nxt = S_IDLE;
        done_nxt  = 1'b1;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: state_nxt = S_TRAP;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are masked during the reset cycle so an aborted instruction cannot emit a strobe.
  assign active   = ~reset;
  assign in_instr = active & (state inside {S_DECODE, S_EXEC, S_MEM, S_WB});

  assign instr_ready = (state == S_IDLE);
  assign busy        = ~instr_ready;

  assign RegDst   = in_instr & ctrl.reg_dst;
  assign ALUSrc   = in_instr & ctrl.alu_src;
  assign MemtoReg = in_instr & ctrl.mem_to_reg;
  assign ALUOP    = in_instr ? ctrl.alu_op : '0;

  assign Branch   = active & (state == S_EXEC) & ctrl.is_beq;
  assign MemRead  = active & (state == S_MEM) & ctrl.is_lw;
  assign MemWrite = active & (state == S_MEM) & ctrl.is_sw;
  assign RegWrite = active & (state == S_WB);
  assign done     = active & done_nxt;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_op = active & (state == S_TRAP);
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: instance 0 runs with MEM_LAT=3 (R/addi/lw/illegal/reset abort), instance 1 with MEM_LAT=1 (sw, beq).
module tb_multicycle_control_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  instr_valid;
  logic [31:0] instruction [2];
  logic [1:0]  instr_ready, busy, done, reg_dst, alu_src, mem_to_reg;
  logic [1:0]  branch, mem_read, mem_write, reg_write, illegal_op;
  logic [1:0]  alu_op [2];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  multicycle_control_unit #(.MEM_LAT(3)) u_dut_lat3 (
    .clock(clock), .reset(reset), .instr_valid(instr_valid[0]), .instr_ready(instr_ready[0]),
    .Instruction(instruction[0]), .RegDst(reg_dst[0]), .ALUSrc(alu_src[0]), .MemtoReg(mem_to_reg[0]),
    .ALUOP(alu_op[0]), .Branch(branch[0]), .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
    .RegWrite(reg_write[0]), .busy(busy[0]), .done(done[0]), .illegal_op(illegal_op[0])
  );

  multicycle_control_unit #(.MEM_LAT(1)) u_dut_lat1 (
    .clock(clock), .reset(reset), .instr_valid(instr_valid[1]), .instr_ready(instr_ready[1]),
    .Instruction(instruction[1]), .RegDst(reg_dst[1]), .ALUSrc(alu_src[1]), .MemtoReg(mem_to_reg[1]),
    .ALUOP(alu_op[1]), .Branch(branch[1]), .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
    .RegWrite(reg_write[1]), .busy(busy[1]), .done(done[1]), .illegal_op(illegal_op[1])
  );

  // Packed order: {ready, busy, done, RegDst, ALUSrc, MemtoReg, ALUOP[1:0], Branch, MemRead, MemWrite, RegWrite, illegal_op}
  function automatic logic [12:0] obs(input int i);
    return {instr_ready[i], busy[i], done[i], reg_dst[i], alu_src[i], mem_to_reg[i], alu_op[i],
            branch[i], mem_read[i], mem_write[i], reg_write[i], illegal_op[i]};
  endfunction

  function automatic logic [12:0] ew(input logic rdy, dn, rd, as, m2r, input logic [1:0] aop,
                                     input logic br, mr, mw, rw, ill);
    return {rdy, ~rdy, dn, rd, as, m2r, aop, br, mr, mw, rw, ill};
  endfunction

  task automatic check(input string tag, input int i, input logic [12:0] expected);
    logic [12:0] observed;
    observed = obs(i);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  logic [12:0] w_idle;

  initial begin
    w_idle         = ew(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    reset          = 1'b1;
    instr_valid    = 2'b01;
    instruction[0] = 32'h0000_4200;
    instruction[1] = 32'h0;

    // Reset with valid held: no transfer, idle outputs on both instances
    tick();
    check("reset_lat3", 0, w_idle);
    check("reset_lat1", 1, w_idle);
    tick();
    check("reset_hold_valid", 0, w_idle);
    reset = 1'b0;

    // R-type: DECODE, EXEC, WB
    tick(); check("r_decode", 0, ew(0, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0));
    tick(); check("r_exec",   0, ew(0, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0));
    tick(); check("r_wb",     0, ew(0, 1, 1, 0, 0, 2'b10, 0, 0, 0, 1, 0));
    instruction[0] = 32'h2008_4200;

    // addi back-to-back after one IDLE cycle
    tick(); check("b2b_idle", 0, w_idle);
    tick(); check("addi_decode", 0, ew(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0));
    instruction[0] = 32'h8C08_0004;
    tick(); check("addi_exec_no_resample", 0, ew(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0));
    tick(); check("addi_wb", 0, ew(0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 1, 0));
    instruction[0] = 32'h0000_4200;

    tick(); check("b2b_idle2", 0, w_idle);
    tick(); check("r2_decode", 0, ew(0, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0));
    tick(); check("r2_exec",   0, ew(0, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0));
    tick(); check("r2_wb",     0, ew(0, 1, 1, 0, 0, 2'b10, 0, 0, 0, 1, 0));
    instruction[0] = 32'h8C08_0004;

    // lw with MEM_LAT=3: MemRead for exactly three cycles, done at +6
    tick(); check("lw_idle", 0, w_idle);
    tick(); check("lw_decode", 0, ew(0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0));
    instr_valid[0] = 1'b0;
    tick(); check("lw_exec", 0, ew(0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      tick(); check($sformatf("lw_mem%0d", k), 0, ew(0, 0, 0, 1, 1, 2'b00, 0, 1, 0, 0, 0));
    end
    tick(); check("lw_wb",    0, ew(0, 1, 0, 1, 1, 2'b00, 0, 0, 0, 1, 0));
    tick(); check("lw_after", 0, w_idle);
    tick(); check("idle_no_valid", 0, w_idle);

    // Illegal opcode
    instruction[0] = 32'hFC00_0000;
    instr_valid[0] = 1'b1;
    tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("ill_decode", 0, ew(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
`else
    check("ill_decode", 0, ew(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
`endif
    instr_valid[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
      check($sformatf("ill_trap%0d", k), 0, ew(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1));
`else
      check($sformatf("ill_nop_idle%0d", k), 0, w_idle);
`endif
    end
    reset = 1'b1;
    tick(); check("ill_reset", 0, w_idle);
    reset = 1'b0;

    // Reset during lw MEM aborts immediately
    instruction[0] = 32'h8C08_0004;
    instr_valid[0] = 1'b1;
    tick(); check("lw2_decode", 0, ew(0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0));
    instr_valid[0] = 1'b0;
    tick();
    tick(); check("lw2_mem", 0, ew(0, 0, 0, 1, 1, 2'b00, 0, 1, 0, 0, 0));
    reset = 1'b1;
    #1 check("lw2_reset_cycle", 0, ew(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    tick(); check("lw2_reset_idle", 0, w_idle);
    reset = 1'b0;
    tick(); check("lw2_post_reset", 0, w_idle);

    // sw then beq on the MEM_LAT=1 instance
    instruction[1] = 32'hAC08_0004;
    instr_valid[1] = 1'b1;
    tick(); check("sw_decode", 1, ew(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0));
    instruction[1] = 32'h1000_0002;
    tick(); check("sw_exec", 1, ew(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0));
    tick(); check("sw_mem",  1, ew(0, 1, 0, 1, 0, 2'b00, 0, 0, 1, 0, 0));
    tick(); check("sw_idle", 1, w_idle);
    tick(); check("beq_decode", 1, ew(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0));
    instr_valid[1] = 1'b0;
    tick(); check("beq_exec", 1, ew(0, 1, 0, 0, 0, 2'b01, 1, 0, 0, 0, 0));
    tick(); check("beq_idle", 1, w_idle);
    check("lat3_quiet", 0, w_idle);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
